// File: rtl/instr_loader_if.sv
// Bundle of the decoded-instruction handshake and the byte-wide instruction
// memory write port shared by the loader and its environment.
interface instr_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [4:0]        in_dest;
    logic [4:0]        in_src1;
    logic [4:0]        in_src2;
    logic [15:0]       in_imm;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_busy;

    // Instruction source plus memory: drives fields and busy, observes the write port.
    modport master (
        output in_valid, in_opcode, in_dest, in_src1, in_src2, in_imm, mem_busy,
        input  in_ready, mem_wr_en, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_opcode, in_dest, in_src1, in_src2, in_imm, mem_busy,
        output in_ready, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Packs decoded instruction fields into 32-bit MIPS words and writes them
// big-endian, one byte per cycle, into the instruction memory.
module instr_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_INSTR = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_start,
    instr_loader_if.slave     bus,
    output logic [ADDR_W-2:0] count,
    output logic              full,
    output logic              illegal
);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_INC = ADDR_W'(4);
    localparam logic [ADDR_W-2:0] MAX_CNT = (ADDR_W-1)'(MAX_INSTR);
    localparam logic [ADDR_W-2:0] CNT_ONE = (ADDR_W-1)'(1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [1:0]        b_q, b_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-2:0] count_q, count_d;
    logic              illegal_q, illegal_d;
    logic              in_ready_q, in_ready_d;
    logic [31:0]       enc_word;
    logic              enc_legal;

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (bus.in_opcode)
            6'd0: enc_word = 32'h0;
            6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12:
                enc_word = {bus.in_opcode, bus.in_dest, bus.in_src1, bus.in_src2, 11'b0};
            6'd32, 6'd33, 6'd36, 6'd37:
                enc_word = {bus.in_opcode, bus.in_dest, bus.in_src1, bus.in_imm};
            6'd40: enc_word = {bus.in_opcode, 5'b0, bus.in_src1, bus.in_imm};
            6'd41: enc_word = {bus.in_opcode, bus.in_src2, bus.in_src1, bus.in_imm};
            6'd42: enc_word = {bus.in_opcode, 10'b0, bus.in_imm};
            default: enc_legal = 1'b0;
        endcase
    end

    assign bus.mem_wr_en = (state_q == WRITE) && !bus.mem_busy;
    assign bus.mem_addr  = ptr_q + {{(ADDR_W-2){1'b0}}, b_q};
    assign bus.mem_wdata = data_q;
    assign bus.in_ready  = in_ready_q;
    assign count         = count_q;
    assign full          = (count_q == MAX_CNT);
    assign illegal       = illegal_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        b_d       = b_q;
        word_d    = word_q;
        data_d    = data_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                // Rewind first so an instruction accepted alongside it lands at BASE.
                if (prog_start) begin
                    ptr_d     = BASE;
                    count_d   = '0;
                    illegal_d = 1'b0;
                end
                if (bus.in_valid && in_ready_q) begin
                    b_d = 2'd0;
                    if (enc_legal) begin
                        word_d  = enc_word;
                        data_d  = enc_word[31:24];
                        state_d = WRITE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                // data_q always holds the byte for the current index, so a stall just holds it.
                if (bus.mem_wr_en) begin
                    b_d = b_q + 2'd1;
                    case (b_q)
                        2'd0: data_d = word_q[23:16];
                        2'd1: data_d = word_q[15:8];
                        2'd2: data_d = word_q[7:0];
                        default: begin
                            ptr_d   = ptr_q + PTR_INC;
                            if (count_q != MAX_CNT) count_d = count_q + CNT_ONE;
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE) && (count_d != MAX_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= BASE;
            b_q        <= 2'd0;
            word_q     <= 32'h0;
            data_q     <= 8'h0;
            count_q    <= '0;
            illegal_q  <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            b_q        <= b_d;
            word_q     <= word_d;
            data_q     <= data_d;
            count_q    <= count_d;
            illegal_q  <= illegal_d;
            in_ready_q <= in_ready_d;
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Directed-vector bench for instr_loader: table of encodings plus hand-written
// stall, rewind, reset-mid-write and full-capacity sequences.
module tb_instr_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       prog_start;
    logic       sm_prog_start;
    logic [8:0] count, sm_count;
    logic       full, sm_full, illegal, sm_illegal;

    instr_loader_if #(.ADDR_W(10)) bus ();
    instr_loader_if #(.ADDR_W(10)) sm_bus ();

    instr_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_INSTR(256)) dut (
        .clk(clk), .rst(rst), .prog_start(prog_start), .bus(bus),
        .count(count), .full(full), .illegal(illegal)
    );

    instr_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_INSTR(2)) dut_small (
        .clk(clk), .rst(rst), .prog_start(sm_prog_start), .bus(sm_bus),
        .count(sm_count), .full(sm_full), .illegal(sm_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  dest;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [15:0] imm;
        logic [31:0] word;
        logic        legal;
        int          addr;
        int          cnt;
        logic        ill;
    } vec_t;

    vec_t vecs [12];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    int         wr_n = 0;
    logic [9:0] wr_addr [256];
    logic [7:0] wr_data [256];
    int         wr_cyc  [256];
    int         sm_wr_n = 0;
    logic [9:0] sm_wr_addr [256];
    logic [7:0] sm_wr_data [256];
    int         sm_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-side monitors log every byte write with the cycle stamp it happened on.
    always @(posedge clk) begin
        if (bus.mem_wr_en && wr_n < 256) begin
            wr_addr[wr_n] = bus.mem_addr;
            wr_data[wr_n] = bus.mem_wdata;
            wr_cyc[wr_n]  = cyc;
            wr_n          = wr_n + 1;
        end
        if (sm_bus.mem_wr_en && sm_wr_n < 256) begin
            sm_wr_addr[sm_wr_n] = sm_bus.mem_addr;
            sm_wr_data[sm_wr_n] = sm_bus.mem_wdata;
            sm_wr_n             = sm_wr_n + 1;
        end
        if (!rst && sm_bus.in_valid && sm_bus.in_ready) sm_hs = sm_hs + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge right after the handshake edge.
    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [15:0] imm, output int hs);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_hs", {31'b0, bus.in_ready}, 32'd1);
        bus.in_opcode = op;
        bus.in_dest   = d;
        bus.in_src1   = s1;
        bus.in_src2   = s2;
        bus.in_imm    = imm;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        hs = cyc;
    endtask

    task automatic waitReady(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.in_ready && k < 50);
    endtask

    task automatic checkWord(input string tag, input int base, input logic [31:0] word,
                             input int addr, input int hs, input int stall);
        logic [31:0] w;
        w = word;
        checkOutput($sformatf("%s_nwr", tag), wr_n - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), {22'b0, wr_addr[base+i]}, addr + i);
            checkOutput($sformatf("%s_data%0d", tag, i), {24'b0, wr_data[base+i]}, {24'b0, w[31-8*i -: 8]});
            checkOutput($sformatf("%s_cyc%0d", tag, i), wr_cyc[base+i], hs + i + ((i >= 2) ? stall : 0));
        end
    endtask

    initial begin
        int hs, k, base, n;

        vecs[0]  = '{6'd1,  5'd3,  5'd4,  5'd5,  16'h0000, 32'h04642800, 1'b1, 0,  1,  1'b0};
        vecs[1]  = '{6'd32, 5'd1,  5'd0,  5'd0,  16'hFFFF, 32'h8020FFFF, 1'b1, 4,  2,  1'b0};
        vecs[2]  = '{6'd42, 5'd0,  5'd0,  5'd0,  16'h0010, 32'hA8000010, 1'b1, 8,  3,  1'b0};
        vecs[3]  = '{6'd2,  5'd1,  5'd2,  5'd3,  16'h1111, 32'h00000000, 1'b0, 12, 3,  1'b1};
        vecs[4]  = '{6'd0,  5'd31, 5'd7,  5'd9,  16'hBEEF, 32'h00000000, 1'b1, 12, 4,  1'b1};
        vecs[5]  = '{6'd33, 5'd2,  5'd7,  5'd0,  16'h1234, 32'h84471234, 1'b1, 16, 5,  1'b1};
        vecs[6]  = '{6'd36, 5'd5,  5'd6,  5'd0,  16'h0008, 32'h90A60008, 1'b1, 20, 6,  1'b1};
        vecs[7]  = '{6'd37, 5'd8,  5'd9,  5'd0,  16'hFFFC, 32'h9509FFFC, 1'b1, 24, 7,  1'b1};
        vecs[8]  = '{6'd40, 5'd31, 5'd10, 5'd3,  16'h0004, 32'hA00A0004, 1'b1, 28, 8,  1'b1};
        vecs[9]  = '{6'd41, 5'd1,  5'd4,  5'd6,  16'hFFF0, 32'hA4C4FFF0, 1'b1, 32, 9,  1'b1};
        vecs[10] = '{6'd12, 5'd31, 5'd30, 5'd29, 16'hFFFF, 32'h33FEE800, 1'b1, 36, 10, 1'b1};
        vecs[11] = '{6'd63, 5'd1,  5'd1,  5'd1,  16'h0001, 32'h00000000, 1'b0, 40, 10, 1'b1};

        rst = 1'b1;
        prog_start = 1'b0;
        sm_prog_start = 1'b0;
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_dest = '0; bus.in_src1 = '0;
        bus.in_src2 = '0; bus.in_imm = '0; bus.mem_busy = 1'b0;
        sm_bus.in_valid = 1'b0; sm_bus.in_opcode = 6'd1; sm_bus.in_dest = 5'd3; sm_bus.in_src1 = 5'd4;
        sm_bus.in_src2 = 5'd5; sm_bus.in_imm = '0; sm_bus.mem_busy = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("rst_wr_en", {31'b0, bus.mem_wr_en}, 32'd0);
        checkOutput("rst_addr", {22'b0, bus.mem_addr}, 32'd0);
        checkOutput("rst_wdata", {24'b0, bus.mem_wdata}, 32'd0);
        checkOutput("rst_count", {23'b0, count}, 32'd0);
        checkOutput("rst_full", {31'b0, full}, 32'd0);
        checkOutput("rst_illegal", {31'b0, illegal}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", {31'b0, bus.in_ready}, 32'd1);

        for (int v = 0; v < 12; v++) begin
            base = wr_n;
            applyStimulus(vecs[v].op, vecs[v].dest, vecs[v].src1, vecs[v].src2, vecs[v].imm, hs);
            checkOutput($sformatf("v%0d_ready_after_hs", v), {31'b0, bus.in_ready}, {31'b0, !vecs[v].legal});
            waitReady(k);
            checkOutput($sformatf("v%0d_ready_lat", v), k, vecs[v].legal ? 32'd4 : 32'd1);
            if (vecs[v].legal) checkWord($sformatf("v%0d", v), base, vecs[v].word, vecs[v].addr, hs, 0);
            else checkOutput($sformatf("v%0d_nwr", v), wr_n - base, 32'd0);
            checkOutput($sformatf("v%0d_count", v), {23'b0, count}, vecs[v].cnt);
            checkOutput($sformatf("v%0d_illegal", v), {31'b0, illegal}, {31'b0, vecs[v].ill});
            checkOutput($sformatf("v%0d_idle_addr", v), {22'b0, bus.mem_addr},
                        vecs[v].addr + (vecs[v].legal ? 4 : 0));
            checkOutput($sformatf("v%0d_idle_wr_en", v), {31'b0, bus.mem_wr_en}, 32'd0);
        end

        prog_start = 1'b1;
        @(negedge clk);
        prog_start = 1'b0;
        checkOutput("rewind_illegal", {31'b0, illegal}, 32'd0);
        checkOutput("rewind_count", {23'b0, count}, 32'd0);
        checkOutput("rewind_addr", {22'b0, bus.mem_addr}, 32'd0);

        base = wr_n;
        applyStimulus(6'd32, 5'd1, 5'd0, 5'd0, 16'hFFFF, hs);
        waitReady(k);
        checkWord("addi", base, 32'h8020FFFF, 0, hs, 0);
        base = wr_n;
        applyStimulus(6'd42, 5'd0, 5'd0, 5'd0, 16'h0010, hs);
        waitReady(k);
        checkWord("jmp", base, 32'hA8000010, 4, hs, 0);
        checkOutput("addi_jmp_count", {23'b0, count}, 32'd2);

        // prog_start during WRITE must not disturb the word in flight.
        base = wr_n;
        applyStimulus(6'd1, 5'd3, 5'd4, 5'd5, 16'h0, hs);
        @(negedge clk);
        prog_start = 1'b1;
        @(negedge clk);
        prog_start = 1'b0;
        waitReady(k);
        checkWord("ps_in_write", base, 32'h04642800, 8, hs, 0);
        checkOutput("ps_in_write_count", {23'b0, count}, 32'd3);

        base = wr_n;
        applyStimulus(6'd1, 5'd3, 5'd4, 5'd5, 16'h0, hs);
        repeat (2) @(negedge clk);
        bus.mem_busy = 1'b1;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            checkOutput($sformatf("busy%0d_wr_en", s), {31'b0, bus.mem_wr_en}, 32'd0);
            checkOutput($sformatf("busy%0d_addr", s), {22'b0, bus.mem_addr}, 32'd14);
            checkOutput($sformatf("busy%0d_wdata", s), {24'b0, bus.mem_wdata}, 32'h28);
        end
        @(negedge clk);
        bus.mem_busy = 1'b0;
        waitReady(k);
        checkOutput("busy_ready_lat", k, 32'd2);
        checkWord("busy", base, 32'h04642800, 12, hs, 3);
        checkOutput("busy_count", {23'b0, count}, 32'd4);

        base = wr_n;
        applyStimulus(6'd33, 5'd2, 5'd7, 5'd0, 16'h1234, hs);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_wr_en", {31'b0, bus.mem_wr_en}, 32'd0);
        checkOutput("midrst_addr", {22'b0, bus.mem_addr}, 32'd0);
        checkOutput("midrst_count", {23'b0, count}, 32'd0);
        checkOutput("midrst_ready", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("midrst_nwr", wr_n - base, 32'd2);
        @(negedge clk);
        rst = 1'b0;
        waitReady(k);
        base = wr_n;
        applyStimulus(6'd36, 5'd5, 5'd6, 5'd0, 16'h0008, hs);
        waitReady(k);
        checkWord("after_rst", base, 32'h90A60008, 0, hs, 0);
        checkOutput("after_rst_count", {23'b0, count}, 32'd1);

        // Capacity-two loader: hold in_valid and confirm it stops accepting at full.
        sm_bus.in_valid = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("sm_hs_at_full", sm_hs, 32'd2);
        checkOutput("sm_nwr_at_full", sm_wr_n, 32'd8);
        checkOutput("sm_full", {31'b0, sm_full}, 32'd1);
        checkOutput("sm_count_full", {23'b0, sm_count}, 32'd2);
        checkOutput("sm_ready_full", {31'b0, sm_bus.in_ready}, 32'd0);
        checkOutput("sm_last_addr", {22'b0, sm_wr_addr[7]}, 32'd7);
        sm_prog_start = 1'b1;
        @(negedge clk);
        sm_prog_start = 1'b0;
        checkOutput("sm_rewind_full", {31'b0, sm_full}, 32'd0);
        n = 0;
        while (sm_hs < 3 && n < 10) begin
            @(negedge clk);
            n++;
        end
        sm_bus.in_valid = 1'b0;
        checkOutput("sm_hs_after_rewind", sm_hs, 32'd3);
        repeat (6) @(negedge clk);
        checkOutput("sm_nwr_after_rewind", sm_wr_n, 32'd12);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w;
            w = 32'h04642800;
            checkOutput($sformatf("sm_rw_addr%0d", i), {22'b0, sm_wr_addr[8+i]}, i);
            checkOutput($sformatf("sm_rw_data%0d", i), {24'b0, sm_wr_data[8+i]}, {24'b0, w[31-8*i -: 8]});
        end
        checkOutput("sm_count_after_rewind", {23'b0, sm_count}, 32'd1);
        checkOutput("sm_full_after_rewind", {31'b0, sm_full}, 32'd0);
        checkOutput("sm_ready_after_rewind", {31'b0, sm_bus.in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
# instr_loader

Instruction encoder and program loader feeding the instruction memory of the 5-stage MIPS pipeline. It accepts one instruction at a time as decoded fields (opcode, dest, src1, src2, imm) over a valid/ready handshake. It packs the fields into the 32-bit instruction format the control unit decodes, and writes the word big-endian, one byte per cycle, into the byte-wide instruction memory write port. It is the write-side counterpart of the decode path: it produces the words that fetch and decode later consume.

## Interface
- ADDR_W, 10, instruction-memory byte address width
- BASE_ADDR, 0, byte address of the first instruction; must be a multiple of 4
- MAX_INSTR, 256, capacity in instructions; `full` asserts at this count
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- prog_start  in  1  pulse that rewinds the write pointer to BASE_ADDR and clears `count` and `illegal`
- in_valid  in  1  instruction fields valid
- in_ready  out  1  loader can accept fields (registered)
- in_opcode  in  6  opcode
- in_dest  in  5  destination register
- in_src1  in  5  source register 1
- in_src2  in  5  source register 2
- in_imm  in  16  immediate
- mem_wr_en  out  1  byte write strobe
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte data
- mem_busy  in  1  memory cannot take a write this cycle
- count  out  ADDR_W-1  instructions written since reset or prog_start
- full  out  1  count == MAX_INSTR
- illegal  out  1  sticky; an unsupported opcode was received

## Operation
- **Encoding:** word = {op[31:26], f1[25:21], f2[20:16], low[15:0]}.
  - R-type ops 1,3,5,6,7,8,9,10,11,12: {op, dest, src1, src2, 11'b0}.
  - 32 ADDI, 33 SUBI, 36 LD: {op, dest, src1, imm}.
  - 37 ST: {op, dest (value reg), src1 (base), imm}.
  - 40 BEZ: {op, 5'b0, src1, imm}.
  - 41 BNE: {op, src2, src1, imm}.
  - 42 JMP: {op, 10'b0, imm}.
  - 0 NOP: 32'h0.
  - Any other opcode is illegal: the handshake still completes, nothing is written, and `illegal` is set. Pointer and count are unchanged.
- **FSM states:** IDLE, WRITE.
  - IDLE: handshake (in_valid && in_ready) latches the encoded word and clears byte index b to 0. Goes to WRITE if the opcode is legal, otherwise stays in IDLE.
  - WRITE: mem_wr_en = !mem_busy; mem_addr = ptr + b; mem_wdata = word[31-8b -: 8] (byte 0 = bits 31:24).
    - Each cycle with mem_wr_en high increments b.
    - After the write with b == 3: ptr += 4, count += 1, return to IDLE.
- **in_ready:** registered; next value = (next state == IDLE) && !(next full).
- **prog_start:**
  - Honoured only in IDLE; ignored in WRITE.
  - If a handshake happens in the same cycle, the rewind applies first. The accepted instruction is written at BASE_ADDR and count ends at 1.
- **Arithmetic:** ptr is ADDR_W bits and does not wrap, because `full` blocks further acceptance. count saturates at MAX_INSTR.

## Timing
- **Reset values:**
  - state IDLE, ptr = BASE_ADDR, b = 0
  - in_ready 0, rising to 1 on the first clk edge after rst falls
  - mem_wr_en 0, mem_addr BASE_ADDR, mem_wdata 0
  - count 0, full 0, illegal 0
- **Latency:** handshake at edge N, then bytes 0..3 at edges N+1..N+4 (no busy). in_ready is high again after edge N+4. Throughput is one instruction per 5 cycles.
- **mem_busy:** each busy cycle inserts one stall. mem_addr and mem_wdata hold, and mem_wr_en is 0.
- **mem_* outputs:** driven from registers only, never combinationally from in_*.
- **Reset mid-WRITE:** everything returns to reset values immediately. Bytes already written remain in memory.
- **In IDLE:** mem_wr_en = 0, mem_addr = ptr, mem_wdata holds its last value.

## Test plan
- **ADD:** reset, then ADD op=1 dest=3 src1=4 src2=5 -> bytes 04,64,28,00 at addresses 0,1,2,3 on 4 consecutive cycles; count=1; in_ready returns after 5 cycles.
- **ADDI:** op=32 dest=1 src1=0 imm=FFFF, then JMP op=42 imm=0010 -> 80,20,FF,FF at 0..3, then A8,00,00,10 at 4..7; count=2.
- **Busy stall:** mem_busy high for 3 cycles while b=2 -> mem_wr_en low 3 cycles with mem_addr=ptr+2 held; word finishes in 8 cycles with correct bytes.
- **Illegal:** op=2 -> handshake completes, no mem_wr_en, illegal=1, count unchanged. Next ADD is written at the same address. prog_start clears illegal.
- **Full and rewind:** MAX_INSTR=2, two legal instructions -> full=1, in_ready=0, in_valid ignored. prog_start together with in_valid -> full=0, instruction written at BASE_ADDR, count=1.
- **Reset mid-write:** rst asserted after byte 1 -> mem_wr_en drops immediately, ptr=0, count=0. A subsequent instruction is rewritten at address 0.
